// File: rtl/ie_op_sequencer_if.sv
// ie_op_sequencer_if: op handshake, decode flags and memory-port bus
// between the decode stage / memory port (master) and the sequencer (slave).
interface ie_op_sequencer_if;
    logic       op_valid;
    logic       op_ready;
    logic       is_load;
    logic       is_store;
    logic       is_branch;
    logic       is_jsr;
    logic       is_rts;
    logic       is_rti;
    logic       is_break;
    logic       is_stack_op;
    logic       is_nop;
    logic       is_flag_inst;
    logic       stack_push;
    logic       branch_taken;
    logic       mem_rdy;
    logic       mem_req;
    logic       mem_we;
    logic [1:0] mem_sel;

    modport master (
        output op_valid, is_load, is_store, is_branch, is_jsr,
        output is_rts, is_rti, is_break, is_stack_op, is_nop,
        output is_flag_inst, stack_push, branch_taken, mem_rdy,
        input  op_ready, mem_req, mem_we, mem_sel
    );

    modport slave (
        input  op_valid, is_load, is_store, is_branch, is_jsr,
        input  is_rts, is_rti, is_break, is_stack_op, is_nop,
        input  is_flag_inst, stack_push, branch_taken, mem_rdy,
        output op_ready, mem_req, mem_we, mem_sel
    );
endinterface

// File: rtl/ie_op_sequencer.sv
// ie_op_sequencer: multi-cycle IE datapath controller, one op at a time.
// Optional mem_rdy wait timeout enabled by defining IE_SEQ_TIMEOUT_EN.
module ie_op_sequencer #(
    parameter int STACK_W     = 2,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic             clk,
    input  logic             rst,
    ie_op_sequencer_if.slave bus,
    output logic             alu_en,
    output logic             reg_wr,
    output logic             sp_inc,
    output logic             sp_dec,
    output logic             pc_load,
    output logic [1:0]       pc_sel,
    output logic             done,
    output logic             err,
    output logic [2:0]       state_o
);
    typedef enum logic [2:0] {
        IDLE, LOAD, EXEC, WB, STACK, PCUPD, DONE
    } state_t;

    typedef enum logic [3:0] {
        C_ALU, C_NOP, C_FLAG, C_BR, C_STK, C_RTI, C_RTS, C_JSR, C_BRK
    } cls_t;

    state_t             state, state_n;
    cls_t               cls, cls_n;
    logic               st, st_n;
    logic               push, push_n;
    logic               ph, ph_n;
    logic [STACK_W-1:0] cnt, cnt_n;
    logic               err_n;
    logic               req_n, we_n;
    logic [1:0]         sel_n, pc_sel_n;
    logic               accept;
    logic               tmo;

    assign accept  = bus.op_valid & bus.op_ready;
    assign state_o = state;
    assign sp_dec  = bus.mem_req & bus.mem_we & bus.mem_rdy &
                     (bus.mem_sel == 2'b01);

`ifdef IE_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] wcnt;

    assign tmo = bus.mem_req & ~bus.mem_rdy &
                 (wcnt == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst || !bus.mem_req || bus.mem_rdy)
            wcnt <= '0;
        else
            wcnt <= wcnt + 1'b1;
    end
`else
    assign tmo = 1'b0;
`endif

    always_comb begin
        state_n = state;
        cls_n   = cls;
        st_n    = st;
        push_n  = push;
        ph_n    = ph;
        cnt_n   = cnt;
        err_n   = err;
        unique case (state)
            IDLE: if (accept) begin
                err_n   = 1'b0;
                st_n    = bus.is_store;
                push_n  = 1'b1;
                ph_n    = 1'b0;
                cnt_n   = '0;
                state_n = STACK;
                priority case (1'b1)
                    bus.is_break: begin
                        cls_n = C_BRK;
                        cnt_n = STACK_W'(3);
                    end
                    bus.is_jsr: begin
                        cls_n = C_JSR;
                        cnt_n = STACK_W'(2);
                    end
                    bus.is_rts: begin
                        cls_n  = C_RTS;
                        cnt_n  = STACK_W'(2);
                        push_n = 1'b0;
                    end
                    bus.is_rti: begin
                        cls_n  = C_RTI;
                        cnt_n  = STACK_W'(3);
                        push_n = 1'b0;
                    end
                    bus.is_stack_op: begin
                        cls_n  = C_STK;
                        cnt_n  = STACK_W'(1);
                        push_n = bus.stack_push;
                    end
                    bus.is_branch: begin
                        cls_n   = C_BR;
                        state_n = bus.branch_taken ? PCUPD : DONE;
                    end
                    bus.is_nop, bus.is_flag_inst: begin
                        cls_n   = bus.is_flag_inst ? C_FLAG : C_NOP;
                        state_n = EXEC;
                    end
                    default: begin
                        cls_n   = C_ALU;
                        state_n = bus.is_load ? LOAD : EXEC;
                    end
                endcase
            end
            LOAD: begin
                if (tmo) begin
                    state_n = DONE;
                    err_n   = 1'b1;
                end else if (bus.mem_rdy) begin
                    state_n = (cls == C_BRK) ? PCUPD : EXEC;
                end
            end
            EXEC: begin
                state_n = (cls == C_NOP || cls == C_FLAG) ? DONE : WB;
            end
            WB: begin
                if (cls == C_ALU && st) begin
                    if (tmo) begin
                        state_n = DONE;
                        err_n   = 1'b1;
                    end else if (bus.mem_rdy) begin
                        state_n = DONE;
                    end
                end else begin
                    state_n = DONE;
                end
            end
            STACK: begin
                // Pulls spend one sp_inc cycle (ph = 0) before each read
                if (!push && !ph) begin
                    ph_n = 1'b1;
                end else if (tmo) begin
                    state_n = DONE;
                    err_n   = 1'b1;
                end else if (bus.mem_rdy) begin
                    cnt_n = cnt - STACK_W'(1);
                    ph_n  = 1'b0;
                    if (cnt == STACK_W'(1)) begin
                        unique case (cls)
                            C_JSR, C_RTS, C_RTI: state_n = PCUPD;
                            C_BRK:               state_n = LOAD;
                            C_STK:               state_n = push ? DONE : WB;
                            default:             state_n = DONE;
                        endcase
                    end
                end
            end
            PCUPD:   state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        req_n = (state_n == LOAD) ||
                (state_n == WB && cls_n == C_ALU && st_n) ||
                (state_n == STACK && (push_n || ph_n));
        we_n  = req_n && (state_n == WB || (state_n == STACK && push_n));
        if (state_n == LOAD && cls_n == C_BRK)
            sel_n = 2'b10;
        else if (state_n == STACK)
            sel_n = 2'b01;
        else
            sel_n = 2'b00;
        unique case (cls_n)
            C_RTS, C_RTI: pc_sel_n = 2'b01;
            C_BRK:        pc_sel_n = 2'b10;
            C_JSR:        pc_sel_n = 2'b11;
            default:      pc_sel_n = 2'b00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cls          <= C_ALU;
            st           <= 1'b0;
            push         <= 1'b0;
            ph           <= 1'b0;
            cnt          <= '0;
            err          <= 1'b0;
            bus.op_ready <= 1'b1;
            bus.mem_req  <= 1'b0;
            bus.mem_we   <= 1'b0;
            bus.mem_sel  <= 2'b00;
            alu_en       <= 1'b0;
            reg_wr       <= 1'b0;
            sp_inc       <= 1'b0;
            pc_load      <= 1'b0;
            pc_sel       <= 2'b00;
            done         <= 1'b0;
        end else begin
            state        <= state_n;
            cls          <= cls_n;
            st           <= st_n;
            push         <= push_n;
            ph           <= ph_n;
            cnt          <= cnt_n;
            err          <= err_n;
            bus.op_ready <= (state_n == IDLE);
            bus.mem_req  <= req_n;
            bus.mem_we   <= we_n;
            bus.mem_sel  <= sel_n;
            alu_en       <= (state_n == EXEC) && (cls_n != C_NOP);
            reg_wr       <= (state_n == WB) && !(cls_n == C_ALU && st_n);
            sp_inc       <= (state_n == STACK) && !push_n && !ph_n;
            pc_load      <= (state_n == PCUPD);
            pc_sel       <= pc_sel_n;
            done         <= (state_n == DONE);
        end
    end
endmodule

// File: tb/tb_ie_op_sequencer.sv
// tb_ie_op_sequencer: directed tests for the IE op sequencer.
// Cycle numbers count from the accept edge (1 = first cycle after accept).
module tb_ie_op_sequencer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       alu_en, reg_wr, sp_inc, sp_dec, pc_load, done, err;
    logic [1:0] pc_sel;
    logic [2:0] state_o;

    int checks = 0;
    int errors = 0;

    int t_alu, t_reg, t_done, t_pcl, t_rdy;
    int n_alu, n_reg, n_inc, n_dec, n_pcl, n_done;
    int n_req, n_rd, n_wr, n_err;
    int acc_sel[4];
    logic [1:0] pcsel;
    logic       err_done;

    ie_op_sequencer_if bus ();

    ie_op_sequencer dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .alu_en  (alu_en),
        .reg_wr  (reg_wr),
        .sp_inc  (sp_inc),
        .sp_dec  (sp_dec),
        .pc_load (pc_load),
        .pc_sel  (pc_sel),
        .done    (done),
        .err     (err),
        .state_o (state_o)
    );

    always #5 clk = ~clk;

    task automatic clr_flags();
        bus.op_valid     = 1'b0;
        bus.is_load      = 1'b0;
        bus.is_store     = 1'b0;
        bus.is_branch    = 1'b0;
        bus.is_jsr       = 1'b0;
        bus.is_rts       = 1'b0;
        bus.is_rti       = 1'b0;
        bus.is_break     = 1'b0;
        bus.is_stack_op  = 1'b0;
        bus.is_nop       = 1'b0;
        bus.is_flag_inst = 1'b0;
        bus.stack_push   = 1'b0;
        bus.branch_taken = 1'b0;
    endtask

    // Issue the op whose flags are already set, then trace n cycles
    // with a memory model that inserts ws wait states per access.
    task automatic go(input int n, input int ws, input bit idle_rdy);
        int w;
        w = ws;
        t_alu = -1; t_reg = -1; t_done = -1; t_pcl = -1; t_rdy = -1;
        n_alu = 0; n_reg = 0; n_inc = 0; n_dec = 0; n_pcl = 0;
        n_done = 0; n_req = 0; n_rd = 0; n_wr = 0; n_err = 0;
        for (int i = 0; i < 4; i++) acc_sel[i] = 0;
        pcsel = 2'bxx;
        err_done = 1'bx;
        @(negedge clk);
        bus.op_valid = 1'b1;
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            if (c == 1) clr_flags();
            if (bus.mem_req) begin
                if (w > 0) begin
                    bus.mem_rdy = 1'b0;
                    w--;
                end else begin
                    bus.mem_rdy = 1'b1;
                    w = ws;
                end
            end else begin
                bus.mem_rdy = idle_rdy;
            end
            #1;
            if (alu_en) begin n_alu++; if (t_alu < 0) t_alu = c; end
            if (reg_wr) begin n_reg++; if (t_reg < 0) t_reg = c; end
            if (done) begin n_done++; if (t_done < 0) t_done = c; end
            if (pc_load) begin
                n_pcl++;
                pcsel = pc_sel;
                if (t_pcl < 0) t_pcl = c;
            end
            if (sp_inc) n_inc++;
            if (sp_dec) n_dec++;
            if (err) n_err++;
            if (done) err_done = err;
            if (bus.mem_req) n_req++;
            if (bus.mem_req && bus.mem_rdy) begin
                if (bus.mem_we) n_wr++;
                else n_rd++;
                acc_sel[bus.mem_sel]++;
            end
            if (bus.op_ready && t_rdy < 0) t_rdy = c;
        end
        bus.mem_rdy = 1'b0;
    endtask

    task automatic test_reset();
        clr_flags();
        bus.mem_rdy = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.op_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b expected 1", bus.op_ready);
        end
        checks++;
        if (state_o !== 3'd0) begin
            errors++;
            $display("FAIL reset_state: got %0d expected 0", state_o);
        end
        checks++;
        if ({alu_en, reg_wr, sp_inc, sp_dec, pc_load, done, err,
             bus.mem_req} !== 8'h00) begin
            errors++;
            $display("FAIL reset_strobes: got %b expected 00000000",
                     {alu_en, reg_wr, sp_inc, sp_dec, pc_load, done,
                      err, bus.mem_req});
        end
        rst = 1'b0;
    endtask

    task automatic test_alu();
        go(8, 0, 1'b1);
        checks++;
        if (t_alu !== 1) begin
            errors++; $display("FAIL alu_alu_en: got %0d expected 1", t_alu);
        end
        checks++;
        if (t_reg !== 2) begin
            errors++; $display("FAIL alu_reg_wr: got %0d expected 2", t_reg);
        end
        checks++;
        if (t_done !== 3 || n_done !== 1) begin
            errors++;
            $display("FAIL alu_done: got t=%0d n=%0d expected t=3 n=1",
                     t_done, n_done);
        end
        checks++;
        if (t_rdy !== 4) begin
            errors++; $display("FAIL alu_ready: got %0d expected 4", t_rdy);
        end
        checks++;
        if (n_req !== 0) begin
            errors++; $display("FAIL alu_no_mem: got %0d expected 0", n_req);
        end
    endtask

    task automatic test_load();
        bus.is_load = 1'b1;
        go(10, 2, 1'b0);
        checks++;
        if (n_req !== 3 || n_rd !== 1 || n_wr !== 0 || acc_sel[0] !== 1) begin
            errors++;
            $display("FAIL load_mem: got req=%0d rd=%0d wr=%0d sel0=%0d expected 3 1 0 1",
                     n_req, n_rd, n_wr, acc_sel[0]);
        end
        checks++;
        if (t_alu !== 4 || t_reg !== 5) begin
            errors++;
            $display("FAIL load_alu_wb: got %0d %0d expected 4 5", t_alu, t_reg);
        end
        checks++;
        if (t_done !== 6) begin
            errors++; $display("FAIL load_done: got %0d expected 6", t_done);
        end
`ifndef IE_SEQ_TIMEOUT_EN
        checks++;
        if (n_err !== 0) begin
            errors++; $display("FAIL load_err: got %0d expected 0", n_err);
        end
`endif
    endtask

    task automatic test_store_rmw();
        bus.is_store = 1'b1;
        go(8, 0, 1'b0);
        checks++;
        if (n_wr !== 1 || n_reg !== 0 || t_done !== 3) begin
            errors++;
            $display("FAIL store: got wr=%0d reg=%0d done=%0d expected 1 0 3",
                     n_wr, n_reg, t_done);
        end
        bus.is_load  = 1'b1;
        bus.is_store = 1'b1;
        go(8, 0, 1'b0);
        checks++;
        if (n_rd !== 1 || n_wr !== 1 || n_reg !== 0 || t_done !== 4) begin
            errors++;
            $display("FAIL rmw: got rd=%0d wr=%0d reg=%0d done=%0d expected 1 1 0 4",
                     n_rd, n_wr, n_reg, t_done);
        end
    endtask

    task automatic test_jsr();
        bus.is_jsr = 1'b1;
        go(10, 0, 1'b0);
        checks++;
        if (n_wr !== 2 || acc_sel[1] !== 2 || n_dec !== 2) begin
            errors++;
            $display("FAIL jsr_push: got wr=%0d sel1=%0d dec=%0d expected 2 2 2",
                     n_wr, acc_sel[1], n_dec);
        end
        checks++;
        if (n_pcl !== 1 || pcsel !== 2'b11 || t_pcl !== 3 || t_done !== 4) begin
            errors++;
            $display("FAIL jsr_pc: got pcl=%0d sel=%b t=%0d done=%0d expected 1 11 3 4",
                     n_pcl, pcsel, t_pcl, t_done);
        end
    endtask

    task automatic test_rti_pull();
        bus.is_rti = 1'b1;
        go(12, 0, 1'b1);
        checks++;
        if (n_inc !== 3 || n_rd !== 3 || acc_sel[1] !== 3 || n_dec !== 0) begin
            errors++;
            $display("FAIL rti_pull: got inc=%0d rd=%0d sel1=%0d dec=%0d expected 3 3 3 0",
                     n_inc, n_rd, acc_sel[1], n_dec);
        end
        checks++;
        if (pcsel !== 2'b01 || t_done !== 8) begin
            errors++;
            $display("FAIL rti_pc: got sel=%b done=%0d expected 01 8", pcsel, t_done);
        end
        bus.is_stack_op = 1'b1;
        bus.stack_push  = 1'b0;
        go(8, 0, 1'b1);
        checks++;
        if (n_inc !== 1 || n_rd !== 1 || t_reg !== 3 || t_done !== 4) begin
            errors++;
            $display("FAIL pull_op: got inc=%0d rd=%0d reg=%0d done=%0d expected 1 1 3 4",
                     n_inc, n_rd, t_reg, t_done);
        end
        bus.is_stack_op = 1'b1;
        bus.stack_push  = 1'b1;
        go(6, 0, 1'b0);
        checks++;
        if (n_wr !== 1 || n_dec !== 1 || n_reg !== 0 || t_done !== 2) begin
            errors++;
            $display("FAIL push_op: got wr=%0d dec=%0d reg=%0d done=%0d expected 1 1 0 2",
                     n_wr, n_dec, n_reg, t_done);
        end
    endtask

    task automatic test_branch_brk();
        bus.is_branch = 1'b1;
        go(5, 0, 1'b0);
        checks++;
        if (t_done !== 1 || n_pcl !== 0) begin
            errors++;
            $display("FAIL br_not_taken: got done=%0d pcl=%0d expected 1 0",
                     t_done, n_pcl);
        end
        bus.is_branch    = 1'b1;
        bus.branch_taken = 1'b1;
        go(5, 0, 1'b0);
        checks++;
        if (t_pcl !== 1 || pcsel !== 2'b00 || t_done !== 2) begin
            errors++;
            $display("FAIL br_taken: got pcl=%0d sel=%b done=%0d expected 1 00 2",
                     t_pcl, pcsel, t_done);
        end
        bus.is_break = 1'b1;
        go(12, 0, 1'b0);
        checks++;
        if (n_wr !== 3 || n_dec !== 3 || n_rd !== 1 || acc_sel[2] !== 1) begin
            errors++;
            $display("FAIL brk_mem: got wr=%0d dec=%0d rd=%0d sel2=%0d expected 3 3 1 1",
                     n_wr, n_dec, n_rd, acc_sel[2]);
        end
        checks++;
        if (pcsel !== 2'b10 || t_pcl !== 5 || t_done !== 6) begin
            errors++;
            $display("FAIL brk_pc: got sel=%b pcl=%0d done=%0d expected 10 5 6",
                     pcsel, t_pcl, t_done);
        end
    endtask

    task automatic test_nop_flag();
        bus.is_nop = 1'b1;
        go(5, 0, 1'b0);
        checks++;
        if (n_alu !== 0 || n_reg !== 0 || t_done !== 2) begin
            errors++;
            $display("FAIL nop: got alu=%0d reg=%0d done=%0d expected 0 0 2",
                     n_alu, n_reg, t_done);
        end
        bus.is_flag_inst = 1'b1;
        go(5, 0, 1'b0);
        checks++;
        if (t_alu !== 1 || n_reg !== 0 || t_done !== 2) begin
            errors++;
            $display("FAIL flag_inst: got alu=%0d reg=%0d done=%0d expected 1 0 2",
                     t_alu, n_reg, t_done);
        end
    endtask

    task automatic test_priority();
        bus.is_break     = 1'b1;
        bus.is_branch    = 1'b1;
        bus.branch_taken = 1'b1;
        bus.is_load      = 1'b1;
        go(12, 0, 1'b0);
        checks++;
        if (n_dec !== 3 || pcsel !== 2'b10 || t_done !== 6) begin
            errors++;
            $display("FAIL priority_brk: got dec=%0d sel=%b done=%0d expected 3 10 6",
                     n_dec, pcsel, t_done);
        end
    endtask

    task automatic test_rst_mid_stack();
        bus.is_jsr = 1'b1;
        go(2, 100, 1'b0);
        checks++;
        if (state_o !== 3'd4 || bus.mem_req !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre: got state=%0d req=%b expected 4 1",
                     state_o, bus.mem_req);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (state_o !== 3'd0 || bus.mem_req !== 1'b0 || bus.op_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_stack: got state=%0d req=%b rdy=%b expected 0 0 1",
                     state_o, bus.mem_req, bus.op_ready);
        end
        rst = 1'b0;
    endtask

`ifdef IE_SEQ_TIMEOUT_EN
    task automatic test_timeout();
        bus.is_load = 1'b1;
        go(20, 1000, 1'b0);
        checks++;
        if (n_req !== 15 || t_done !== 16 || err_done !== 1'b1) begin
            errors++;
            $display("FAIL timeout: got req=%0d done=%0d err=%b expected 15 16 1",
                     n_req, t_done, err_done);
        end
        checks++;
        if (err !== 1'b1 || bus.mem_req !== 1'b0) begin
            errors++;
            $display("FAIL timeout_sticky: got err=%b req=%b expected 1 0",
                     err, bus.mem_req);
        end
        go(5, 0, 1'b0);
        checks++;
        if (n_err !== 0 || t_done !== 3) begin
            errors++;
            $display("FAIL timeout_clear: got err_cycles=%0d done=%0d expected 0 3",
                     n_err, t_done);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_store_rmw();
        test_jsr();
        test_rti_pull();
        test_branch_brk();
        test_nop_flag();
        test_priority();
        test_rst_mid_stack();
`ifdef IE_SEQ_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ie_op_sequencer.md
Name: ie_op_sequencer

Overview:
- Multi-cycle controller for the IE datapath. Accepts one decoded op per handshake, with flags from the simple-op decoder plus a branch-taken bit.
- Sequences the operand load, ALU step, writeback/store, stack push/pop and PC update, then pulses done.
- Sits between the decode stage and the ALU/register file/memory-port strobes. Executes one op at a time; no pipelining.

Parameters:
- STACK_W, 2: width of the stack byte counter. Must be able to hold 3.
- TIMEOUT_CYC, 15: maximum wait cycles on mem_rdy. Used only when IE_SEQ_TIMEOUT_EN is defined.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- op_valid  in  1  decoded op available
- op_ready  out  1  sequencer accepts op; high only in IDLE
- is_load, is_store, is_branch, is_jsr, is_rts, is_rti, is_break, is_stack_op, is_nop, is_flag_inst  in  1 each  decode flags; sampled on accept
- stack_push  in  1  for is_stack_op: 1 = push, 0 = pull
- branch_taken  in  1  branch condition result; sampled on accept
- mem_rdy  in  1  memory port completes the current access this cycle
- mem_req  out  1  memory access request; held until mem_rdy
- mem_we  out  1  1 = write, 0 = read; valid while mem_req is high
- mem_sel  out  2  00 operand address, 01 stack address, 10 vector address
- alu_en  out  1  ALU/flag-update strobe
- reg_wr  out  1  register/status writeback strobe
- sp_inc, sp_dec  out  1 each  stack-pointer step strobes
- pc_load  out  1  load PC
- pc_sel  out  2  00 branch target, 01 stack bytes, 10 vector, 11 jsr target
- done  out  1  one-cycle completion pulse
- err  out  1  sticky timeout error; cleared on reset or on the next accept
- state_o  out  3  current state, for debug

Behaviour:
- Reset: state = IDLE; all outputs 0 except op_ready = 1; internal counters cleared.
- States: IDLE, LOAD, EXEC, WB, STACK, PCUPD, DONE.
- Accept condition: op_valid & op_ready. Flags are registered on accept.
- Classification priority: break > jsr > rts > rti > stack_op > branch > nop/flag_inst > load/store/ALU.
- Plain ALU op, no memory: IDLE -> EXEC (alu_en) -> WB (reg_wr) -> DONE.
- is_load: IDLE -> LOAD (mem_req, mem_we = 0, mem_sel = 00, held until mem_rdy) -> EXEC -> WB -> DONE.
- is_store: IDLE -> EXEC -> WB. In WB, mem_req with mem_we = 1 and mem_sel = 00 is held until mem_rdy; reg_wr stays 0. Then DONE.
- is_load and is_store together (read-modify-write): LOAD -> EXEC -> WB (store) -> DONE.
- nop / flag_inst: IDLE -> EXEC (alu_en only if flag_inst) -> DONE.
- Branch:
  - Taken: IDLE -> PCUPD (pc_load, pc_sel = 00) -> DONE.
  - Not taken: IDLE -> DONE.
- STACK state loads a byte count on entry, then performs one memory access per byte with mem_sel = 01. Each access is held until mem_rdy.
  - Push: mem_we = 1; sp_dec pulses in the mem_rdy cycle.
  - Pull: mem_we = 0; sp_inc pulses in the cycle before each read.
  - Counts: jsr push 2; rts pull 2; rti pull 3; break push 3; stack_op 1.
- After STACK:
  - jsr: PCUPD with pc_sel = 11.
  - rts, rti: PCUPD with pc_sel = 01.
  - break: one vector read (LOAD, mem_sel = 10), then PCUPD with pc_sel = 10.
  - Pull stack_op: WB (reg_wr).
  - Push stack_op: DONE.
- DONE: done = 1 for one cycle, then IDLE. op_ready returns to 1 the cycle after done.
- mem_rdy in the same cycle mem_req first rises completes the access immediately (zero wait states).
- mem_rdy while mem_req = 0 is ignored.
- Strobes alu_en, reg_wr, sp_inc, sp_dec, pc_load and done are single-cycle pulses.
- rst mid-operation: returns to IDLE on the next edge and drops mem_req immediately. No partial stack fix-up.
- Minimum latency, accept to done: 1 cycle (not-taken branch). ALU register op: 3 cycles.

Optional Feature:
- Macro: IE_SEQ_TIMEOUT_EN.
- Defined:
  - A wait counter runs while mem_req = 1 and mem_rdy = 0.
  - When the counter reaches TIMEOUT_CYC, err is set, mem_req drops, and the FSM goes to DONE (done pulses), then IDLE.
  - The counter clears on every mem_rdy.
- Undefined: no counter; waits indefinitely; err is tied to 0.

Test Plan:
- Reset: rst high for 2 cycles -> op_ready = 1, state_o = IDLE, all strobes 0. Accept with no flags set -> alu_en at +1, reg_wr at +2, done at +3.
- Load with 2 wait states: is_load = 1, mem_rdy low for 2 cycles -> mem_req high for 3 cycles with mem_we = 0, then alu_en, reg_wr, done. done at accept +6.
- JSR: is_jsr with zero-wait memory -> 2 write accesses on mem_sel = 01, 2 sp_dec pulses, pc_load with pc_sel = 11, then done.
- RTI: 3 reads with 3 sp_inc pulses, then pc_load with pc_sel = 01. Pull stack_op (is_stack_op, stack_push = 0): 1 read, 1 sp_inc, then reg_wr.
- Branches and BRK: not-taken branch -> done 1 cycle after accept, no pc_load. BRK -> 3 pushes, then a vector read on mem_sel = 10, then pc_load with pc_sel = 10.
- Timeout (IE_SEQ_TIMEOUT_EN defined): is_load with mem_rdy held low -> after 15 wait cycles err = 1, mem_req = 0, done pulses. Next accept clears err. Also assert rst mid-STACK -> IDLE on the next edge, mem_req = 0.
